fifo_serial_drain: RTL and testbench

Read-side consumer for the 32x16 synchronous FIFO. It watches the FIFO empty flag and pops one 16-bit word at a time with a single-cycle read strobe. Each word is transmitted on a single-wire serial line as a framed, parity-protected character. It sits between the FIFO's `RD`/`DOUT`/`QUEUE_EMPTY` side and an off-block serial link.

---
 rtl/fifo_serial_drain.sv | 140 ++++++++++++++
 tb/tb_fifo_serial_drain.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_serial_drain.sv
// Read-side FIFO consumer: pops one word at a time and sends it as a framed,
// parity-protected serial character (start, DATA_W bits MSB first, parity, stop).
module fifo_serial_drain #(
   parameter int DATA_W     = 16,
   parameter int BIT_DIV    = 4,
   parameter int PARITY_ODD = 0
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              ENABLE,
   input  logic              QUEUE_EMPTY,
   output logic              RD,
   input  logic [DATA_W-1:0] DOUT,
   output logic              TX,
   output logic              BUSY,
   output logic [15:0]       WORD_CNT
);

   localparam int DIV_W = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
   localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_POP, S_CAPT, S_START, S_DATA, S_PARITY, S_STOP
   } state_t;

   state_t            r_state;
   logic [DIV_W-1:0]  r_div;
   logic [BIT_W-1:0]  r_bit;
   logic [DATA_W-1:0] r_shift;
   logic              r_par;
   logic              r_rd;
   logic              r_tx;
   logic              r_busy;
   logic [15:0]       r_cnt;

   logic w_go;
   logic w_bit_end;

   assign w_go      = ENABLE & ~QUEUE_EMPTY;
   assign w_bit_end = (r_div == DIV_LAST);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state <= S_IDLE;
         r_div   <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_par   <= 1'b0;
         r_rd    <= 1'b0;
         r_tx    <= 1'b1;
         r_busy  <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_rd <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_go) begin
                  r_state <= S_POP;
                  r_rd    <= 1'b1;
                  r_busy  <= 1'b1;
               end
            end
            S_POP: begin
               r_state <= S_CAPT;
            end
            // DOUT is valid in this cycle, one cycle after the read strobe
            S_CAPT: begin
               r_shift <= DOUT;
               r_par   <= (PARITY_ODD != 0) ? ~^DOUT : ^DOUT;
               r_div   <= '0;
               r_tx    <= 1'b0;
               r_state <= S_START;
            end
            S_START: begin
               if (w_bit_end) begin
                  r_div   <= '0;
                  r_bit   <= '0;
                  r_tx    <= r_shift[DATA_W-1];
                  r_shift <= {r_shift[DATA_W-2:0], 1'b0};
                  r_state <= S_DATA;
               end else begin
                  r_div <= r_div + 1'b1;
               end
            end
            S_DATA: begin
               if (w_bit_end) begin
                  r_div <= '0;
                  if (r_bit == BIT_LAST) begin
                     r_tx    <= r_par;
                     r_state <= S_PARITY;
                  end else begin
                     r_bit   <= r_bit + 1'b1;
                     r_tx    <= r_shift[DATA_W-1];
                     r_shift <= {r_shift[DATA_W-2:0], 1'b0};
                  end
               end else begin
                  r_div <= r_div + 1'b1;
               end
            end
            S_PARITY: begin
               if (w_bit_end) begin
                  r_div   <= '0;
                  r_tx    <= 1'b1;
                  r_state <= S_STOP;
               end else begin
                  r_div <= r_div + 1'b1;
               end
            end
            S_STOP: begin
               if (w_bit_end) begin
                  r_div <= '0;
                  r_cnt <= r_cnt + 16'd1;
                  if (w_go) begin
                     r_state <= S_POP;
                     r_rd    <= 1'b1;
                  end else begin
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
                  end
               end else begin
                  r_div <= r_div + 1'b1;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_tx    <= 1'b1;
            end
         endcase
      end
   end

   assign RD       = r_rd;
   assign TX       = r_tx;
   assign BUSY     = r_busy;
   assign WORD_CNT = r_cnt;

endmodule

// File: tb/tb_fifo_serial_drain.sv
// Bench for fifo_serial_drain: two instances (BIT_DIV=4 even, BIT_DIV=1 odd) fed by
// FIFO models, checked every cycle against a frame-timeline model plus literal pins.
module tb_fifo_serial_drain;

   localparam int BDV [2] = '{4, 1};
   localparam int ODD [2] = '{0, 1};

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  en = 2'b00;
   logic [1:0]  qe;
   logic [1:0]  rd;
   logic [1:0]  tx;
   logic [1:0]  busy;
   logic [15:0] dout [2];
   logic [15:0] cnt  [2];

   logic [15:0] mem [2][32];
   int          wp [2];
   int          rp [2];

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   bit hist [2][4096];
   int rdq0 [$];
   int rdq1 [$];

   // model state: position within the current pop-to-stop timeline
   bit          m_act [2];
   int          m_t   [2];
   logic [15:0] m_word[2];
   logic [15:0] m_cnt [2];
   int          m_rd  [2];

   always #5 clk = ~clk;

   fifo_serial_drain #(.DATA_W(16), .BIT_DIV(4), .PARITY_ODD(0)) u_dut0 (
      .CLK(clk), .RST_N(rst_n), .ENABLE(en[0]), .QUEUE_EMPTY(qe[0]), .RD(rd[0]),
      .DOUT(dout[0]), .TX(tx[0]), .BUSY(busy[0]), .WORD_CNT(cnt[0])
   );

   fifo_serial_drain #(.DATA_W(16), .BIT_DIV(1), .PARITY_ODD(1)) u_dut1 (
      .CLK(clk), .RST_N(rst_n), .ENABLE(en[1]), .QUEUE_EMPTY(qe[1]), .RD(rd[1]),
      .DOUT(dout[1]), .TX(tx[1]), .BUSY(busy[1]), .WORD_CNT(cnt[1])
   );

   for (genvar gi = 0; gi < 2; gi++) begin : g_qe
      assign qe[gi] = (wp[gi] == rp[gi]);
   end

   initial begin
      for (int k = 0; k < 2; k++) begin
         wp[k] = 0; rp[k] = 0; dout[k] = '0;
         m_act[k] = 0; m_t[k] = 0; m_word[k] = '0; m_cnt[k] = '0; m_rd[k] = 0;
      end
   end

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (rd[k]) begin
            dout[k] <= mem[k][rp[k] % 32];
            rp[k]   <= rp[k] + 1;
         end
      end
   end

   function automatic logic par_of(input logic [15:0] w, input int odd);
      int ones = 0;
      for (int i = 0; i < 16; i++) ones += int'(w[i]);
      return ((ones % 2) == 1) ^ (odd != 0);
   endfunction

   task automatic chk(input string nm, input int k, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s inst%0d cyc %0d: got %h expected %h", nm, k, cyc, got, exp);
      end
   endtask

   // Model update: a frame is the 2 pop/capture cycles plus 19 bit slots.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      for (int k = 0; k < 2; k++) begin
         if (!rst_n) begin
            m_act[k] = 0; m_t[k] = 0; m_cnt[k] = '0;
         end else begin
            if (m_act[k]) begin
               m_t[k] = m_t[k] + 1;
               if (m_t[k] == 2 + 19 * BDV[k]) begin
                  m_act[k] = 0;
                  m_cnt[k] = m_cnt[k] + 16'd1;
               end
            end
            if (!m_act[k] && en[k] && !qe[k]) begin
               m_act[k]  = 1;
               m_t[k]    = 0;
               m_word[k] = mem[k][m_rd[k] % 32];
               m_rd[k]   = m_rd[k] + 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         logic e_rd, e_tx, e_busy;
         int b;
         e_rd = 1'b0; e_tx = 1'b1; e_busy = 1'b0;
         if (rst_n && m_act[k]) begin
            e_rd   = (m_t[k] == 0);
            e_busy = 1'b1;
            if (m_t[k] >= 2) begin
               b = (m_t[k] - 2) / BDV[k];
               if (b == 0)       e_tx = 1'b0;
               else if (b <= 16) e_tx = m_word[k][16 - b];
               else if (b == 17) e_tx = par_of(m_word[k], ODD[k]);
               else              e_tx = 1'b1;
            end
         end
         chk("rd", k, 32'(rd[k]), 32'(e_rd));
         chk("tx", k, 32'(tx[k]), 32'(e_tx));
         chk("busy", k, 32'(busy[k]), 32'(e_busy));
         chk("word_cnt", k, 32'(cnt[k]), 32'(rst_n ? m_cnt[k] : 16'd0));
         hist[k][cyc % 4096] = tx[k];
         if (rd[k]) begin
            if (k == 0) rdq0.push_back(cyc); else rdq1.push_back(cyc);
            $display("inst%0d pop at cycle %0d", k, cyc);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push(input int k, input logic [15:0] v);
      mem[k][wp[k] % 32] = v;
      wp[k] = wp[k] + 1;
   endtask

   task automatic wait_rd(input int k, input int n, output int r);
      int lim = 0;
      while (((k == 0) ? rdq0.size() : rdq1.size()) <= n && lim < 200) begin
         tick(1);
         lim++;
      end
      if (lim >= 200) begin
         chk("rd_timeout", k, 32'd0, 32'd1);
         r = cyc;
      end else begin
         r = (k == 0) ? rdq0[n] : rdq1[n];
      end
   endtask

   task automatic tick_to(input int c);
      while (cyc < c) tick(1);
   endtask

   initial begin
      int r;
      logic [18:0] fr;
      logic [15:0] bw;

      tick(3);
      chk("reset_tx", 0, 32'(tx[0]), 32'd1);
      chk("reset_cnt", 0, 32'(cnt[0]), 32'd0);
      rst_n = 1'b1;

      // empty FIFO with enable high
      en = 2'b11;
      tick(200);
      chk("empty_rd_count", 0, 32'(rdq0.size()), 32'd0);
      chk("empty_rd_count", 1, 32'(rdq1.size()), 32'd0);
      chk("empty_cnt", 0, 32'(cnt[0]), 32'd0);

      // single word, literal frame check at mid-bit
      push(0, 16'hA5C3);
      wait_rd(0, 0, r);
      tick(90);
      fr = 19'b0_1010010111000011_0_1;
      for (int i = 0; i < 19; i++)
         chk("single_frame_bit", 0, 32'(hist[0][(r + 2 + 4 * i + 2) % 4096]), 32'(fr[18 - i]));
      chk("single_gap_before_start", 0, 32'(hist[0][(r + 1) % 4096]), 32'd1);
      chk("single_cnt", 0, 32'(cnt[0]), 32'd1);
      chk("single_busy", 0, 32'(busy[0]), 32'd0);
      chk("single_rd_count", 0, 32'(rdq0.size()), 32'd1);

      // burst of three
      push(0, 16'h0001); push(0, 16'hFFFF); push(0, 16'h8000);
      wait_rd(0, 1, r);
      tick(3 * 78 + 20);
      chk("burst_rd_count", 0, 32'(rdq0.size()), 32'd4);
      if (rdq0.size() >= 4) begin
         chk("burst_spacing1", 0, 32'(rdq0[2] - rdq0[1]), 32'd78);
         chk("burst_spacing2", 0, 32'(rdq0[3] - rdq0[2]), 32'd78);
         chk("burst_par0", 0, 32'(hist[0][(rdq0[1] + 70) % 4096]), 32'd1);
         chk("burst_par1", 0, 32'(hist[0][(rdq0[2] + 70) % 4096]), 32'd0);
         chk("burst_par2", 0, 32'(hist[0][(rdq0[3] + 70) % 4096]), 32'd1);
      end
      chk("burst_cnt", 0, 32'(cnt[0]), 32'd4);
      chk("burst_empty", 0, 32'(qe[0]), 32'd1);

      // enable dropped during data bit 5 of the first of two words
      push(0, 16'h1234); push(0, 16'h5678);
      wait_rd(0, 4, r);
      tick_to(r + 28);
      en[0] = 1'b0;
      tick(120);
      chk("drop_rd_count", 0, 32'(rdq0.size()), 32'd5);
      chk("drop_cnt", 0, 32'(cnt[0]), 32'd5);
      chk("drop_fifo_level", 0, 32'(wp[0] - rp[0]), 32'd1);
      en[0] = 1'b1;
      tick(100);
      chk("drop_resume_cnt", 0, 32'(cnt[0]), 32'd6);

      // reset during data bit 8
      push(0, 16'h0F0F);
      wait_rd(0, 6, r);
      tick_to(r + 40);
      rst_n = 1'b0;
      #1;
      chk("rst_tx", 0, 32'(tx[0]), 32'd1);
      chk("rst_busy", 0, 32'(busy[0]), 32'd0);
      chk("rst_cnt", 0, 32'(cnt[0]), 32'd0);
      tick(2);
      rst_n = 1'b1;
      tick(5);
      chk("rst_no_reread", 0, 32'(rdq0.size()), 32'd7);
      push(0, 16'h1357);
      wait_rd(0, 7, r);
      tick(90);
      chk("rst_fresh_par", 0, 32'(hist[0][(r + 70) % 4096]), 32'd0);
      chk("rst_fresh_cnt", 0, 32'(cnt[0]), 32'd1);

      // odd parity, one clock per bit
      push(1, 16'h0000); push(1, 16'h0007);
      wait_rd(1, 0, r);
      tick(60);
      chk("odd_rd_count", 1, 32'(rdq1.size()), 32'd2);
      if (rdq1.size() >= 2) begin
         chk("odd_spacing", 1, 32'(rdq1[1] - rdq1[0]), 32'd21);
         chk("odd_start", 1, 32'(hist[1][(rdq1[0] + 2) % 4096]), 32'd0);
         chk("odd_par0", 1, 32'(hist[1][(rdq1[0] + 19) % 4096]), 32'd1);
         chk("odd_stop", 1, 32'(hist[1][(rdq1[0] + 20) % 4096]), 32'd1);
         bw = 16'h0007;
         for (int i = 0; i < 16; i++)
            chk("odd_data1", 1, 32'(hist[1][(rdq1[1] + 3 + i) % 4096]), 32'(bw[15 - i]));
         chk("odd_par1", 1, 32'(hist[1][(rdq1[1] + 19) % 4096]), 32'd0);
      end
      chk("odd_cnt", 1, 32'(cnt[1]), 32'd2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
